// File: rtl/lstm_fixed_pkg.sv
// rtl/lstm_fixed_pkg.sv - shared sign-magnitude fixed-point types and helpers for the LSTM datapath
package lstm_fixed_pkg;

   localparam int WIDTH     = 12;
   localparam int FRAC_BITS = 6;
   localparam int MAX_MAG   = (1 << (WIDTH - 1)) - 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   // Negative zero maps to 0 because -0 == 0; result is sign-extended from bit acc_w-1.
   function automatic logic signed [63:0] sm_to_tc(input logic [WIDTH-1:0] word, input int acc_w);
      logic signed [63:0] mag;
      logic signed [63:0] res;
      mag = 64'(word[WIDTH-2:0]);
      res = word[WIDTH-1] ? -mag : mag;
      res = (res <<< (64 - acc_w)) >>> (64 - acc_w);
      return res;
   endfunction

endpackage

// File: rtl/fixed_sat_pack.sv
// rtl/fixed_sat_pack.sv - two's-complement to saturated sign-magnitude packer
module fixed_sat_pack #(
   parameter int WIDTH = 12,
   parameter int ACC_W = 18
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic [WIDTH-1:0]        word,
   output logic                    sat
);

   localparam logic [ACC_W-1:0] MAX_MAG = ACC_W'((1 << (WIDTH - 1)) - 1);

   logic             neg;
   logic [ACC_W-1:0] mag;

   // A zero input has neg=0, so the packed word never carries a negative zero.
   always_comb begin
      neg = acc[ACC_W-1];
      mag = neg ? -acc : acc;
      sat = (mag > MAX_MAG);
      if (sat) begin
         word = {neg, {(WIDTH - 1){1'b1}}};
      end else begin
         word = {neg, mag[WIDTH-2:0]};
      end
   end

endmodule

// File: rtl/fixed_mac_accum.sv
// rtl/fixed_mac_accum.sv - bias-seeded dot-product accumulator with saturated sign-magnitude output
module fixed_mac_accum
   import lstm_fixed_pkg::*;
#(
   parameter int WIDTH   = 12,
   parameter int VEC_LEN = 16,
   parameter int GUARD   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] bias,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_prod,
   input  logic             in_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             busy
);

   localparam int ACC_W = WIDTH + GUARD;
   localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   state_t                  state, state_nxt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_tc;
   logic signed [ACC_W-1:0] bias_tc;
   logic signed [ACC_W-1:0] sum;
   logic [CNT_W-1:0]        cnt;
   logic                    ovf;
   logic                    fire;
   logic                    last;
   logic [WIDTH-1:0]        sat_word;
   logic                    sat_flag;

   assign prod_tc = ACC_W'(sm_to_tc(in_prod, ACC_W));
   assign bias_tc = ACC_W'(sm_to_tc(bias, ACC_W));
   assign sum     = acc + prod_tc;
   assign fire    = in_valid && in_ready;
   assign last    = (cnt == CNT_W'(VEC_LEN - 1));

   fixed_sat_pack #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_sat_pack (
      .acc  (sum),
      .word (sat_word),
      .sat  (sat_flag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (fire && last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == DONE);
      busy      = (state == ACCUM) || (state == DONE);
   end

   // The final beat is packed straight from acc+prod so out_valid follows with one cycle of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            acc <= bias_tc;
            cnt <= '0;
            ovf <= 1'b0;
         end else if (fire) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | in_ovf;
            if (last) begin
               out_data <= sat_word;
               out_ovf  <= ovf | in_ovf | sat_flag;
            end
         end
      end
   end

endmodule

// File: tb/tb_fixed_mac_accum.sv
// tb/tb_fixed_mac_accum.sv - randomized self-checking bench against an integer reference model
module tb_fixed_mac_accum;

   localparam int W = 12;
   localparam int N = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  bias = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_prod = '0;
   logic          in_ovf = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_ovf;
   logic          busy;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  prod_q [N];
   bit            povf_q [N];

   fixed_mac_accum #(.WIDTH(W), .VEC_LEN(N), .GUARD(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_ovf    (in_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sm_val(input logic [W-1:0] w);
      int m;
      m = int'(w[W-2:0]);
      return w[W-1] ? -m : m;
   endfunction

   // Returns {ovf, data}: exact integer sum, then saturate to +-2047.
   function automatic logic [W:0] model(input logic [W-1:0] b);
      int s;
      bit f;
      s = sm_val(b);
      f = 1'b0;
      for (int i = 0; i < N; i++) begin
         s = s + sm_val(prod_q[i]);
         f = f | povf_q[i];
      end
      if (s > 2047)  return {1'b1, 12'h7FF};
      if (s < -2047) return {1'b1, 12'hFFF};
      if (s < 0)     return {f, 1'b1, 11'(-s)};
      return {f, 1'b0, 11'(s)};
   endfunction

   task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b, input int split);
      for (int i = 0; i < N; i++) begin
         prod_q[i] = (i < split) ? a : b;
         povf_q[i] = 1'b0;
      end
   endtask

   task automatic run_vector(input logic [W-1:0] b, input bit gaps, input int hold);
      logic [W:0] exp;
      exp = model(b);
      check("idle_busy", busy, 0);
      start = 1'b1;
      bias  = b;
      @(posedge clk); #1;
      start = 1'b0;
      check("accum_ready", in_ready, 1);
      check("accum_busy", busy, 1);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_prod  = prod_q[i];
         in_ovf   = povf_q[i];
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_ovf   = 1'b0;
         if (i == N - 2) check("no_early_valid", out_valid, 0);
      end
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp[W-1:0]);
      check("out_ovf", out_ovf, exp[W]);
      check("done_in_ready", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         start = 1'b1;
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, exp[W-1:0]);
         check("hold_ovf", out_ovf, exp[W]);
         check("hold_in_ready", in_ready, 0);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      start     = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_busy", busy, 0);
      check("post_data_kept", out_data, exp[W-1:0]);
      @(posedge clk); #1;
      check("idle_after", busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      fill(12'h040, 12'h040, N);
      run_vector(12'h000, 1'b0, 0);
      run_vector(12'h000, 1'b1, 0);

      fill(12'h080, 12'h880, 8);
      run_vector(12'h020, 1'b0, 5);

      fill(12'h200, 12'h200, N);
      run_vector(12'h000, 1'b0, 1);

      fill(12'hA00, 12'hA00, N);
      run_vector(12'h000, 1'b0, 0);

      for (int i = 0; i < N; i++) begin
         prod_q[i] = (i % 2 == 0) ? 12'h0C0 : 12'h8C0;
         povf_q[i] = 1'b0;
      end
      run_vector(12'h800, 1'b0, 0);

      fill(12'h040, 12'h040, N);
      povf_q[2] = 1'b1;
      run_vector(12'h000, 1'b1, 2);

      for (int v = 0; v < 20; v++) begin
         for (int i = 0; i < N; i++) begin
            prod_q[i] = W'($urandom_range(0, 4095));
            povf_q[i] = ($urandom_range(0, 15) == 0);
         end
         run_vector(W'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      fill(12'h200, 12'h200, N);
      run_vector(12'h000, 1'b0, 0);

      start = 1'b1;
      bias  = 12'h100;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_prod  = 12'h100;
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_ovf", out_ovf, 0);
      check("mid_rst_busy", busy, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("held_rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      fill(12'h040, 12'h040, N);
      run_vector(12'h000, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
